// File: rtl/nibble_packer_pkg.sv
// nibble_packer_pkg
//   Shared constants, FSM state type and slot placement helper for the
//   nibble packer. Optional feature macro used by the design:
//   NIBBLE_PACKER_COUNT_EN (adds the out_count port).
package nibble_packer_pkg;

    localparam int NIB_W         = 4;
    localparam int NIBS_PER_WORD = 32;
    localparam int WORD_W        = 128;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } np_state_t;

    // Lowest bit position of nibble slot 'slot' inside the 128-bit word.
    // LSB-first puts slot 0 at [3:0]; MSB-first puts slot 0 at [127:124].
    function automatic logic [6:0] slot_offset(input logic [4:0] slot,
                                               input bit         lsb_first);
        logic [6:0] base;
        base = {slot, 2'b00};
        if (lsb_first) begin
            return base;
        end else begin
            return 7'd124 - base;
        end
    endfunction

endpackage

// File: rtl/nibble_packer_outreg.sv
// nibble_packer_outreg
//   Output register of the nibble packer and its valid/ready logic.
//   A load always wins; otherwise a taken word (out_valid && out_ready)
//   clears out_valid while out_data keeps its last value.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture load_data this edge
//   load_data[127:0] completed word from the assembly side
//   load_count[5:0] real nibble count of that word (NIBBLE_PACKER_COUNT_EN)
//   out_ready       consumer takes the word this cycle
//   out_valid       out_data holds a complete word
//   out_data[127:0] packed word
//   out_count[5:0]  registered real nibble count (NIBBLE_PACKER_COUNT_EN)
// Macro: NIBBLE_PACKER_COUNT_EN
module nibble_packer_outreg
    import nibble_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
`ifdef NIBBLE_PACKER_COUNT_EN
    input  logic [5:0]        load_count,
`endif
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data
`ifdef NIBBLE_PACKER_COUNT_EN
    ,
    output logic [5:0]        out_count
`endif
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NIBBLE_PACKER_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (load) begin
            out_count <= load_count;
        end
    end
`endif

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer
//   Packs a stream of 4-bit nibbles into 128-bit words. Nibbles are
//   assembled in asm_buf; a word completes on the 32nd nibble or on an
//   accepted in_last, and unfilled slots keep the PAD value.
//   Handshake: a transfer happens on a cycle where valid && ready are both
//   high; valid never waits on ready, and in_ready depends only on the FSM.
// Parameters:
//   PAD        pad nibble written into unfilled slots
//   LSB_FIRST  1: slot k at [4k+3:4k]; 0: slot k at [127-4k -: 4]
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_nib data, in_last ends word
//   out_valid/out_ready   output handshake, out_data packed word
//   out_count[5:0]        real nibbles in out_data (NIBBLE_PACKER_COUNT_EN)
// Macro: NIBBLE_PACKER_COUNT_EN
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter logic [3:0] PAD       = 4'h0,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_nib,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data
`ifdef NIBBLE_PACKER_COUNT_EN
    ,
    output logic [5:0]        out_count
`endif
);

    localparam logic [WORD_W-1:0] PAD_WORD = {NIBS_PER_WORD{PAD}};

    np_state_t         state, state_next;
    logic [WORD_W-1:0] asm_buf, asm_next;
    logic [4:0]        cnt, cnt_next;

    logic              accept;
    logic              complete;
    logic              out_free;
    logic              load;
    logic [WORD_W-1:0] filled;
    logic [WORD_W-1:0] load_data;

    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;
    assign complete = (cnt == 5'd31) || in_last;
    assign out_free = !out_valid || out_ready;

    // Current buffer with the incoming nibble dropped into slot cnt.
    always_comb begin
        filled = asm_buf;
        filled[slot_offset(cnt, LSB_FIRST) +: NIB_W] = in_nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            asm_buf <= PAD_WORD;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            asm_buf <= asm_next;
            cnt     <= cnt_next;
        end
    end

    // On entering HOLD, cnt is deliberately left at the index of the last
    // written slot, so cnt + 1 is the real nibble count in both load paths.
    always_comb begin
        state_next = state;
        asm_next   = asm_buf;
        cnt_next   = cnt;
        load       = 1'b0;
        load_data  = filled;
        case (state)
            FILL: begin
                if (accept) begin
                    if (complete) begin
                        if (out_free) begin
                            load     = 1'b1;
                            asm_next = PAD_WORD;
                            cnt_next = '0;
                        end else begin
                            asm_next   = filled;
                            state_next = HOLD;
                        end
                    end else begin
                        asm_next = filled;
                        cnt_next = cnt + 5'd1;
                    end
                end
            end
            HOLD: begin
                // out_valid is necessarily high here, so out_ready alone
                // frees the output register.
                if (out_ready) begin
                    load       = 1'b1;
                    load_data  = asm_buf;
                    asm_next   = PAD_WORD;
                    cnt_next   = '0;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

`ifdef NIBBLE_PACKER_COUNT_EN
    logic [5:0] load_count;
    assign load_count = {1'b0, cnt} + 6'd1;
`endif

    nibble_packer_outreg u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (load_data),
`ifdef NIBBLE_PACKER_COUNT_EN
        .load_count (load_count),
`endif
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data)
`ifdef NIBBLE_PACKER_COUNT_EN
        ,
        .out_count  (out_count)
`endif
    );

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer
//   Bench for nibble_packer. Three instances share one stimulus stream:
//   dut0 PAD=0 LSB_FIRST=1, dut1 PAD=A LSB_FIRST=1, dut2 PAD=0 LSB_FIRST=0.
//   A reference model built from a queue of accepted nibbles predicts the
//   ready/valid/data behaviour every cycle.
module tb_nibble_packer;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic [3:0] in_nib;
    logic in_last;
    logic out_ready;

    logic in_ready0, in_ready1, in_ready2;
    logic out_valid0, out_valid1, out_valid2;
    logic [127:0] out_data0, out_data1, out_data2;
`ifdef NIBBLE_PACKER_COUNT_EN
    logic [5:0] out_count0, out_count1, out_count2;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0]   cur_q[$];
    logic [127:0] exp_q[$];
    bit           m_hold;
    bit           m_ov;
    logic [127:0] m_od0, m_od1, m_od2;
    logic [5:0]   m_oc;

    logic [127:0] w1, w2;

    always #5 clk = ~clk;

    nibble_packer #(.PAD(4'h0), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_nib(in_nib), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0)
`ifdef NIBBLE_PACKER_COUNT_EN
        , .out_count(out_count0)
`endif
    );

    nibble_packer #(.PAD(4'hA), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_nib(in_nib), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1)
`ifdef NIBBLE_PACKER_COUNT_EN
        , .out_count(out_count1)
`endif
    );

    nibble_packer #(.PAD(4'h0), .LSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_nib(in_nib), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2)
`ifdef NIBBLE_PACKER_COUNT_EN
        , .out_count(out_count2)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Word built from the nibbles collected so far, rest filled with pad.
    function automatic logic [127:0] pack(input logic [3:0] pad, input bit lsb);
        logic [127:0] w;
        w = {32{pad}};
        foreach (cur_q[k]) begin
            if (lsb) w[4*k +: 4] = cur_q[k];
            else     w[124-4*k +: 4] = cur_q[k];
        end
        return w;
    endfunction

    task automatic model_reset();
        cur_q.delete();
        exp_q.delete();
        m_hold = 1'b0;
        m_ov   = 1'b0;
        m_od0  = '0;
        m_od1  = '0;
        m_od2  = '0;
        m_oc   = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid0", out_valid0, m_ov);
        chk("out_valid1", out_valid1, m_ov);
        chk("out_valid2", out_valid2, m_ov);
        chk("out_data0", out_data0, m_od0);
        chk("out_data1", out_data1, m_od1);
        chk("out_data2", out_data2, m_od2);
`ifdef NIBBLE_PACKER_COUNT_EN
        chk("out_count0", out_count0, m_oc);
        chk("out_count2", out_count2, m_oc);
`endif
    endtask

    // Asynchronous reset applied while the clock is low; outputs are checked
    // before any rising edge occurs.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_nib = 4'h0;
        out_ready = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_cnt", dut0.cnt, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check combinational ready, advance the
    // model across the edge, then check registered outputs.
    task automatic cycle(input logic v, input logic [3:0] n, input logic l, input logic r);
        bit acc, free, ld;
        logic [127:0] front;
        @(negedge clk);
        in_valid = v;
        in_nib = n;
        in_last = l;
        out_ready = r;
        #1;
        chk("in_ready0", in_ready0, !m_hold);
        chk("in_ready1", in_ready1, !m_hold);
        chk("in_ready2", in_ready2, !m_hold);
        if (out_valid0 && out_ready) begin
            chk("sb_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                front = exp_q.pop_front();
                chk("sb_word", out_data0, front);
            end
        end
        acc  = v && !m_hold;
        free = !m_ov || r;
        ld   = 1'b0;
        if (m_hold) begin
            if (r) ld = 1'b1;
        end else if (acc) begin
            cur_q.push_back(n);
            if (cur_q.size() == 32 || l) begin
                if (free) ld = 1'b1;
                else m_hold = 1'b1;
            end
        end
        if (ld) begin
            m_od0 = pack(4'h0, 1'b1);
            m_od1 = pack(4'hA, 1'b1);
            m_od2 = pack(4'h0, 1'b0);
            m_oc  = 6'(cur_q.size());
            m_ov  = 1'b1;
            exp_q.push_back(m_od0);
            cur_q.delete();
            m_hold = 1'b0;
        end else if (m_ov && r) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_nib = 4'h0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Full word 0..F,0..F, consumer always ready.
        for (int i = 0; i < 32; i++) cycle(1'b1, i[3:0], 1'b0, 1'b1);
        chk("full_word", out_data0, 128'hFEDCBA98_76543210_FEDCBA98_76543210);

        // Short frame 1,2,3 with in_last, PAD = A on dut1.
        cycle(1'b1, 4'h1, 1'b0, 1'b1);
        cycle(1'b1, 4'h2, 1'b0, 1'b1);
        cycle(1'b1, 4'h3, 1'b1, 1'b1);
        chk("short_pad", out_data1, {{29{4'hA}}, 4'h3, 4'h2, 4'h1});
`ifdef NIBBLE_PACKER_COUNT_EN
        chk("short_count", out_count1, 6'd3);
`endif
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Two back-to-back words with the consumer stalled.
        for (int i = 0; i < 32; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        w1 = m_od0;
        for (int i = 0; i < 32; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        w2 = pack(4'h0, 1'b1);
        chk("hold_in_ready", in_ready0, 1'b0);
        chk("hold_word1", out_data0, w1);
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        chk("hold_stable", out_data0, w1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        chk("release_word2", out_data0, w2);
        chk("release_in_ready", in_ready0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // MSB-first single nibble frame on dut2.
        cycle(1'b1, 4'h9, 1'b1, 1'b1);
        chk("msb_first", out_data2, {4'h9, 124'h0});
        cycle(1'b0, 4'h0, 1'b0, 1'b1);

        // Reset in the middle of a word, then a clean full word.
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'hF, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 4'(i * 7), 1'b0, 1'b1);
        w1 = '0;
        for (int i = 0; i < 32; i++) w1[4*i +: 4] = 4'(i * 7);
        chk("post_reset_word", out_data0, w1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
